// File: rtl/multiple_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiple_xfer_seq
// Purpose  : Execute-stage sequencer for LDM/STM/PUSH/POP. Latches the
//            register list, drives the external list counter, and issues one
//            data-memory transfer per listed register (lowest first), honouring
//            memory wait states. Finishes with a base-register writeback and
//            stalls the pipeline while busy.
// Ports    : clk/rst_n          clock, synchronous active-low reset
//            i_start..i_rn_val  request and operands from decode
//            o_lc_* / i_lc_*    list-counter stage interface
//            o_dm_* / i_dm_*    data-memory transfer interface
//            o_rf_*             register-file index/strobe/data
//            o_pc_load          pulse when r15 is loaded (branch flush)
//            o_busy / o_done    pipeline stall / end-of-operation pulse
// Revision : 1.0 - initial release
// ============================================================================
module multiple_xfer_seq #(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic              i_is_load,
  input  logic [LIST_W-1:0] i_reg_list,
  input  logic [3:0]        i_base_idx,
  input  logic [ADDR_W-1:0] i_rn_val,
  output logic [LIST_W-1:0] o_lc_list,
  output logic [ADDR_W-1:0] o_lc_addr_in,
  output logic              o_lc_pulse,
  output logic [1:0]        o_lc_vector,
  output logic [ADDR_W-1:0] o_lc_bit_count,
  input  logic [LIST_W-1:0] i_lc_next_list,
  input  logic [ADDR_W-1:0] i_lc_dm_addr,
  input  logic [3:0]        i_lc_reg_addr,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [ADDR_W-1:0] o_dm_addr,
  input  logic              i_dm_ready,
  input  logic [ADDR_W-1:0] i_dm_rdata,
  output logic [3:0]        o_rf_addr,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_wdata,
  output logic              o_pc_load,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [1:0] C_MODE_PUSH = 2'b10;
  localparam logic [1:0] C_MODE_LDM  = 2'b00;

  logic [1:0]        r_state;
  logic [LIST_W-1:0] r_list;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_mode;
  logic              r_load;
  logic [3:0]        r_base;
  logic [ADDR_W-1:0] r_rn;
  logic [ADDR_W-1:0] r_count;
  logic              r_wb_en;
  logic              r_empty_done;

  logic [ADDR_W-1:0] w_count_in;
  logic              w_base_in_list;
  logic              w_push;
  logic              w_active;

  // Byte count of the transfer block: 4 * popcount(list).
  always_comb begin
    w_count_in = '0;
    for (int i = 0; i < LIST_W; i++) begin
      if (i_reg_list[i]) w_count_in = w_count_in + ADDR_W'(4);
    end
  end

  // List bit for Rn: r0-r7 map directly, r14 -> bit 8, r15 -> bit 9.
  always_comb begin
    w_base_in_list = 1'b0;
    if (i_base_idx < 4'd8)        w_base_in_list = i_reg_list[i_base_idx[2:0]];
    else if (i_base_idx == 4'd14) w_base_in_list = i_reg_list[8];
    else if (i_base_idx == 4'd15) w_base_in_list = i_reg_list[9];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_list       <= '0;
      r_addr       <= '0;
      r_mode       <= '0;
      r_load       <= 1'b0;
      r_base       <= '0;
      r_rn         <= '0;
      r_count      <= '0;
      r_wb_en      <= 1'b0;
      r_empty_done <= 1'b0;
    end else begin
      r_empty_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_list  <= i_reg_list;
            r_mode  <= i_mode;
            r_load  <= i_is_load;
            r_base  <= i_base_idx;
            r_rn    <= i_rn_val;
            r_count <= w_count_in;
            // LDM with Rn in the list leaves Rn holding the loaded value.
            r_wb_en <= !((i_mode == C_MODE_LDM) && i_is_load && w_base_in_list);
            if (i_reg_list != '0) r_state <= S_FIRST;
            else                  r_empty_done <= 1'b1;
          end
        end
        S_FIRST, S_XFER: begin
          if (i_dm_ready) begin
            r_list  <= i_lc_next_list;
            r_addr  <= i_lc_dm_addr;
            r_state <= (i_lc_next_list == '0) ? S_WB : S_XFER;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push   = (r_mode == C_MODE_PUSH);
  assign w_active = (r_state == S_FIRST) || (r_state == S_XFER);

  always_comb begin
    o_lc_list      = '0;
    o_lc_addr_in   = '0;
    o_lc_pulse     = 1'b0;
    o_lc_vector    = '0;
    o_lc_bit_count = '0;
    o_dm_req       = 1'b0;
    o_dm_we        = 1'b0;
    o_dm_addr      = '0;
    o_rf_addr      = '0;
    o_rf_we        = 1'b0;
    o_rf_wdata     = '0;
    o_pc_load      = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;

    if (r_state == S_IDLE) begin
      o_done = r_empty_done;
    end else begin
      o_busy         = 1'b1;
      o_lc_list      = r_list;
      o_lc_vector    = r_mode;
      o_lc_bit_count = r_count;
    end

    if (w_active) begin
      o_dm_req  = 1'b1;
      o_dm_addr = i_lc_dm_addr;
      o_rf_addr = i_lc_reg_addr;
      o_dm_we   = !r_load;
      if (r_state == S_FIRST) begin
        // PUSH descends: the block starts count bytes below SP.
        o_lc_pulse   = 1'b1;
        o_lc_addr_in = w_push ? (r_rn - r_count) : r_rn;
      end else begin
        o_lc_addr_in = r_addr;
      end
      if (r_load && i_dm_ready) begin
        o_rf_we    = 1'b1;
        o_rf_wdata = i_dm_rdata;
        o_pc_load  = (i_lc_reg_addr == 4'd15);
      end
    end

    if (r_state == S_WB) begin
      o_done     = 1'b1;
      o_rf_addr  = r_base;
      o_rf_we    = r_wb_en;
      o_rf_wdata = w_push ? (r_rn - r_count) : (r_rn + r_count);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiple_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiple_xfer_seq
// Purpose  : Self-checking bench for multiple_xfer_seq. Models the list
//            counter, drives a vector table of multi-register operations and
//            compares memory/register-file activity against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiple_xfer_seq;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_mode;
  logic        i_is_load;
  logic [9:0]  i_reg_list;
  logic [3:0]  i_base_idx;
  logic [31:0] i_rn_val;
  logic [9:0]  o_lc_list;
  logic [31:0] o_lc_addr_in;
  logic        o_lc_pulse;
  logic [1:0]  o_lc_vector;
  logic [31:0] o_lc_bit_count;
  logic [9:0]  w_lc_next_list;
  logic [31:0] w_lc_dm_addr;
  logic [3:0]  w_lc_reg_addr;
  logic        o_dm_req;
  logic        o_dm_we;
  logic [31:0] o_dm_addr;
  logic        i_dm_ready;
  logic [31:0] i_dm_rdata;
  logic [3:0]  o_rf_addr;
  logic        o_rf_we;
  logic [31:0] o_rf_wdata;
  logic        o_pc_load;
  logic        o_busy;
  logic        o_done;

  multiple_xfer_seq #(.ADDR_W(32), .LIST_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_mode         (i_mode),
    .i_is_load      (i_is_load),
    .i_reg_list     (i_reg_list),
    .i_base_idx     (i_base_idx),
    .i_rn_val       (i_rn_val),
    .o_lc_list      (o_lc_list),
    .o_lc_addr_in   (o_lc_addr_in),
    .o_lc_pulse     (o_lc_pulse),
    .o_lc_vector    (o_lc_vector),
    .o_lc_bit_count (o_lc_bit_count),
    .i_lc_next_list (w_lc_next_list),
    .i_lc_dm_addr   (w_lc_dm_addr),
    .i_lc_reg_addr  (w_lc_reg_addr),
    .o_dm_req       (o_dm_req),
    .o_dm_we        (o_dm_we),
    .o_dm_addr      (o_dm_addr),
    .i_dm_ready     (i_dm_ready),
    .i_dm_rdata     (i_dm_rdata),
    .o_rf_addr      (o_rf_addr),
    .o_rf_we        (o_rf_we),
    .o_rf_wdata     (o_rf_wdata),
    .o_pc_load      (o_pc_load),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] regmap(input int j);
    if (j < 8)  return 4'(j);
    if (j == 8) return 4'd14;
    return 4'd15;
  endfunction

  // List counter: pulse passes the start address through, otherwise +4;
  // current register is the lowest set bit, which is then cleared.
  always_comb begin
    w_lc_reg_addr  = 4'd0;
    w_lc_dm_addr   = o_lc_pulse ? o_lc_addr_in : (o_lc_addr_in + 32'd4);
    w_lc_next_list = o_lc_list & (o_lc_list - 10'd1);
    for (int j = 9; j >= 0; j--) begin
      if (o_lc_list[j]) w_lc_reg_addr = regmap(j);
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic        load;
    logic [9:0]  list;
    logic [3:0]  base;
    logic [31:0] rn;
    int          waits;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        spam;
  } vec_t;

  typedef struct packed {
    logic        wb;
    logic        empty;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  ra;
    logic        rwe;
    logic [31:0] wd;
    logic        pcl;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdf(input vec_t v, input int k);
    if (k == 0) return v.rd0;
    if (k == 1) return v.rd1;
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   32'(o_busy), 0);
    chk({tag, "_done"},   32'(o_done), 0);
    chk({tag, "_dm_req"}, 32'(o_dm_req), 0);
    chk({tag, "_dm_we"},  32'(o_dm_we), 0);
    chk({tag, "_dm_addr"}, o_dm_addr, 0);
    chk({tag, "_rf_we"},  32'(o_rf_we), 0);
    chk({tag, "_rf_addr"}, 32'(o_rf_addr), 0);
    chk({tag, "_rf_wdata"}, o_rf_wdata, 0);
    chk({tag, "_pc_load"}, 32'(o_pc_load), 0);
    chk({tag, "_lc_pulse"}, 32'(o_lc_pulse), 0);
    chk({tag, "_lc_list"}, 32'(o_lc_list), 0);
    chk({tag, "_lc_addr_in"}, o_lc_addr_in, 0);
    chk({tag, "_lc_vector"}, 32'(o_lc_vector), 0);
    chk({tag, "_lc_bit_count"}, o_lc_bit_count, 0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int    n, k, wc, bc, exp_busy;
    bit    fin;
    exp_t  e;
    logic [31:0] start_a;
    string tg;
    tg = $sformatf("v%0d", id);

    n = 0;
    for (int j = 0; j < 10; j++) if (v.list[j]) n++;
    start_a = (v.mode == 2'b10) ? (v.rn - 32'(4 * n)) : v.rn;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      if (v.list[j]) begin
        e      = '0;
        e.addr = start_a + 32'(4 * k);
        e.ra   = regmap(j);
        e.we   = !v.load;
        e.rwe  = v.load;
        e.wd   = v.load ? rdf(v, k) : 32'd0;
        e.pcl  = v.load && (regmap(j) == 4'd15);
        sb.push_back(e);
        k++;
      end
    end
    e       = '0;
    e.wb    = 1'b1;
    e.empty = (n == 0);
    e.ra    = v.base;
    e.rwe   = v.wb_we;
    e.wd    = v.wb_data;
    sb.push_back(e);
    exp_busy = (n == 0) ? 0 : n * (v.waits + 1) + 1;

    i_start    = 1'b1;
    i_mode     = v.mode;
    i_is_load  = v.load;
    i_reg_list = v.list;
    i_base_idx = v.base;
    i_rn_val   = v.rn;
    i_dm_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the request inputs: the DUT must work from latched copies.
    i_start    = v.spam;
    i_reg_list = 10'($urandom_range(1, 1023));
    i_rn_val   = $urandom;
    i_base_idx = 4'($urandom_range(0, 15));
    i_mode     = 2'($urandom_range(0, 3));
    i_is_load  = 1'($urandom_range(0, 1));

    k = 0; wc = 0; bc = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      i_dm_ready = (wc >= v.waits);
      i_dm_rdata = i_dm_ready ? rdf(v, k) : 32'hDEAD_BEEF;
      #4;
      if (o_busy) begin
        bc++;
        chk({tg, "_lc_bit_count"}, o_lc_bit_count, 32'(4 * n));
        chk({tg, "_lc_vector"}, 32'(o_lc_vector), 32'(v.mode));
      end
      if (o_dm_req) begin
        chk({tg, "_lc_pulse"}, 32'(o_lc_pulse), 32'(k == 0));
        if (sb.size() == 0 || sb[0].wb) begin
          chk({tg, "_unexpected_req"}, 32'(o_dm_req), 0);
        end else if (i_dm_ready) begin
          e = sb.pop_front();
          chk({tg, "_dm_addr"}, o_dm_addr, e.addr);
          chk({tg, "_dm_we"}, 32'(o_dm_we), 32'(e.we));
          chk({tg, "_rf_addr"}, 32'(o_rf_addr), 32'(e.ra));
          chk({tg, "_rf_we"}, 32'(o_rf_we), 32'(e.rwe));
          if (e.rwe) chk({tg, "_rf_wdata"}, o_rf_wdata, e.wd);
          chk({tg, "_pc_load"}, 32'(o_pc_load), 32'(e.pcl));
          k++;
          wc = 0;
        end else begin
          chk({tg, "_hold_addr"}, o_dm_addr, sb[0].addr);
          chk({tg, "_hold_we"}, 32'(o_dm_we), 32'(sb[0].we));
          chk({tg, "_hold_rf_addr"}, 32'(o_rf_addr), 32'(sb[0].ra));
          chk({tg, "_hold_rf_we"}, 32'(o_rf_we), 0);
          chk({tg, "_hold_pc_load"}, 32'(o_pc_load), 0);
          wc++;
        end
      end
      if (o_done) begin
        if (sb.size() == 0 || !sb[0].wb) begin
          chk({tg, "_early_done"}, 32'(o_done), 0);
        end else begin
          e = sb.pop_front();
          chk({tg, "_done_dm_req"}, 32'(o_dm_req), 0);
          chk({tg, "_done_pc_load"}, 32'(o_pc_load), 0);
          chk({tg, "_wb_rf_we"}, 32'(o_rf_we), 32'(e.rwe));
          if (e.empty) begin
            chk({tg, "_empty_busy"}, 32'(o_busy), 0);
          end else begin
            chk({tg, "_wb_rf_addr"}, 32'(o_rf_addr), 32'(e.ra));
            chk({tg, "_wb_rf_wdata"}, o_rf_wdata, e.wd);
          end
        end
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_start    = 1'b0;
    i_dm_ready = 1'b0;
    if (!fin) chk({tg, "_timeout_done"}, 0, 1);
    chk({tg, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    chk({tg, "_sb_empty"}, 32'(sb.size()), 0);
    sb.delete();
    // One idle cycle: nothing may be pending or re-triggered.
    #4;
    chk({tg, "_idle_busy"}, 32'(o_busy), 0);
    chk({tg, "_idle_done"}, 32'(o_done), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //           mode   ld    list     base   rn             w  rd0            rd1            wb_data        we    spam
    vecs[0] = '{2'b10, 1'b0, 10'h130, 4'd13, 32'h2000_0100, 0, 32'h0,         32'h0,         32'h2000_00F4, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 1'b1, 10'h201, 4'd13, 32'h2000_00F8, 0, 32'h0000_0011, 32'h0000_0201, 32'h2000_0100, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 1'b1, 10'h006, 4'd2,  32'h0000_0100, 0, 32'hA1A1_0001, 32'hB2B2_0002, 32'h0000_0108, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 1'b0, 10'h008, 4'd0,  32'h3000_0000, 3, 32'h0,         32'h0,         32'h3000_0004, 1'b1, 1'b0};
    vecs[4] = '{2'b00, 1'b0, 10'h000, 4'd1,  32'h0000_0055, 0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0};
    vecs[5] = '{2'b00, 1'b1, 10'h0FF, 4'd5,  32'hFFFF_FFF8, 1, 32'h1111_1111, 32'h2222_2222, 32'h0000_0018, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 1'b0, 10'h1FF, 4'd13, 32'h0000_0010, 0, 32'h0,         32'h0,         32'hFFFF_FFEC, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 1'b0, 10'h082, 4'd7,  32'h0000_0040, 0, 32'h0,         32'h0,         32'h0000_0048, 1'b1, 1'b0};
    vecs[8] = '{2'b01, 1'b1, 10'h003, 4'd13, 32'h0000_1000, 2, 32'hAAAA_5555, 32'h1234_5678, 32'h0000_1008, 1'b1, 1'b0};

    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_mode     = 2'b00;
    i_is_load  = 1'b0;
    i_reg_list = '0;
    i_base_idx = '0;
    i_rn_val   = '0;
    i_dm_ready = 1'b0;
    i_dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    #4 check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a 4-register STM abandons it.
    i_start    = 1'b1;
    i_mode     = 2'b00;
    i_is_load  = 1'b0;
    i_reg_list = 10'h00F;
    i_base_idx = 4'd6;
    i_rn_val   = 32'h0000_0200;
    i_dm_ready = 1'b1;
    @(posedge clk); #1;      // FIRST
    i_start = 1'b0;
    #4 chk("abort_first_req", 32'(o_dm_req), 1);
    @(posedge clk); #1;      // XFER
    #4 chk("abort_xfer_addr", o_dm_addr, 32'h0000_0204);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    #4 check_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #4 check_all_zero("abort_idle");
    @(posedge clk); #1;
    run_vec(100, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
